// File: rtl/serial_sched_pkg.sv
// Shared types and default sizing for the round-robin vector serializer
// and the layer output banks feeding it.
package serial_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MAX_COUNT  = 20;
    localparam int unsigned DEF_NUM_REQ    = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant over req, searching
// upward from ptr+1 with wrap. No grant when en is low.
module rr_arbiter
    import serial_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = PW'((32'(ptr) + i) % NUM_REQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_sched.sv
// Round-robin scheduler: captures one producer's parallel vector, then
// streams it word by word over valid/ready. Option: SERIAL_SCHED_BACK2BACK_EN.
module serial_sched
    import serial_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_COUNT  = DEF_MAX_COUNT,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [DATA_WIDTH-1:0]         req_data [NUM_REQ][MAX_COUNT],
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_COUNT);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_COUNT - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         out_id_q, out_id_d;
    logic [DATA_WIDTH-1:0] buf_q [MAX_COUNT];

    logic                  streaming;
    logic                  is_last;
    logic                  arb_en;
    logic                  capture;
    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_idx;

    assign streaming = (state_q == STREAM);
    assign is_last   = streaming && (beat_cnt_q == LAST_IDX);

    // Arbitration is also opened on the completing last beat when back-to-back
    // mode is built in; rst_n gating keeps req_ready low while held in reset.
`ifdef SERIAL_SCHED_BACK2BACK_EN
    assign arb_en = rst_n && (!streaming || (is_last && out_ready));
`else
    assign arb_en = rst_n && !streaming;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        out_id_d   = out_id_q;
        capture    = 1'b0;

        unique case (state_q)
            IDLE: begin
                capture = |gnt;
            end
            STREAM: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        capture    = |gnt;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture from either state overrides the return to IDLE above,
        // so the back-to-back path needs no separate state branch.
        if (capture) begin
            state_d    = STREAM;
            beat_cnt_d = '0;
            out_id_d   = gnt_idx;
            rr_ptr_d   = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            out_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            out_id_q   <= out_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < MAX_COUNT; k++) begin
                buf_q[k] <= '0;
            end
        end else if (capture) begin
            for (int unsigned k = 0; k < MAX_COUNT; k++) begin
                buf_q[k] <= req_data[gnt_idx][k];
            end
        end
    end

    assign req_ready = gnt;
    assign out_valid = streaming;
    assign out_data  = streaming ? buf_q[beat_cnt_q] : '0;
    assign out_last  = is_last;
    assign out_id    = out_id_q;
    assign busy      = streaming;

endmodule

// File: tb/tb_serial_sched.sv
// Self-checking bench for serial_sched: directed table, corner sequences,
// and randomized traffic against a behavioural scheduler model.
module tb_serial_sched;

    localparam int unsigned DW = 32;
    localparam int unsigned MC = 20;
    localparam int unsigned NR = 4;
`ifdef SERIAL_SCHED_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [DW-1:0] req_data [NR][MC];
    logic [NR-1:0] req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_id;
    logic          out_ready;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_sched #(
        .DATA_WIDTH (DW),
        .MAX_COUNT  (MC),
        .NUM_REQ    (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] exp_ready;
        int            exp_id;
    } arb_vec_t;

    arb_vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic fill(input int r, input logic [DW-1:0] base);
        for (int k = 0; k < int'(MC); k++) req_data[r][k] = base + DW'(k);
    endtask

    // Streams one whole vector, stalling 3 cycles before each beat flagged in mask.
    task automatic drain(input int exp_id, input logic [DW-1:0] base, input logic [MC-1:0] mask);
        for (int k = 0; k < int'(MC); k++) begin
            if (((mask >> k) & 1) != 0) begin
                for (int s = 0; s < 3; s++) begin
                    out_ready = 1'b0;
                    #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, base + DW'(k));
                    chk("stall_last", out_last, k == int'(MC) - 1);
                    chk("stall_id", out_id, exp_id);
                    tick();
                end
            end
            out_ready = 1'b1;
            #1;
            chk("beat_valid", out_valid, 1);
            chk("beat_data", out_data, base + DW'(k));
            chk("beat_last", out_last, k == int'(MC) - 1);
            chk("beat_id", out_id, exp_id);
            chk("beat_no_ready", req_ready, 0);
            tick();
        end
        out_ready = 1'b0;
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int i = 1; i <= int'(NR); i++) begin
            int c;
            c = (ptr + i) % int'(NR);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        tbl[0] = '{4'b1111, 4'b0001, 0};
        tbl[1] = '{4'b1111, 4'b0010, 1};
        tbl[2] = '{4'b1001, 4'b1000, 3};
        tbl[3] = '{4'b0110, 4'b0010, 1};
        tbl[4] = '{4'b0011, 4'b0001, 0};
        tbl[5] = '{4'b0100, 4'b0100, 2};
        tbl[6] = '{4'b0000, 4'b0000, 0};
        tbl[7] = '{4'b0111, 4'b0001, 0};

        for (int r = 0; r < int'(NR); r++) fill(r, '0);

        // Reset held with every requester asking.
        rst_n     = 1'b0;
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_id", out_id, 0);
        end

        // Single request from requester 2.
        rst_n     = 1'b1;
        out_ready = 1'b0;
        fill(2, 32'd100);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("single_ready_drop", req_ready, 0);
        drain(2, 32'd100, '0);
        #1;
        chk("single_idle", busy, 0);

        // Arbitration table, rr pointer carried from row to row.
        do_reset();
        for (int row = 0; row < 8; row++) begin
            for (int r = 0; r < int'(NR); r++) fill(r, DW'(r * 1000 + row * 10000));
            req_valid = tbl[row].valid;
            #1;
            chk("tbl_ready", req_ready, tbl[row].exp_ready);
            tick();
            req_valid = '0;
            if (tbl[row].exp_ready != 0) begin
                drain(tbl[row].exp_id, DW'(tbl[row].exp_id * 1000 + row * 10000), '0);
            end
            #1;
            chk("tbl_idle", busy, 0);
        end

        // Backpressure on beats 0, 7 and 19.
        fill(3, 32'd500);
        req_valid = 4'b1000;
        #1;
        chk("bp_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        drain(3, 32'd500, MC'((1 << 0) | (1 << 7) | (1 << 19)));
        #1;
        chk("bp_idle", busy, 0);

        // All four requesting continuously.
        do_reset();
        for (int r = 0; r < int'(NR); r++) fill(r, DW'(r * 1000));
        req_valid = '1;
        out_ready = 1'b1;
        begin
            int vec = 0, beat = 0, bubbles = 0, cyc = 0;
            bit started = 1'b0;
            while (vec < 5 && cyc < 400) begin
                #1;
                if (out_valid) begin
                    started = 1'b1;
                    chk("cont_id", out_id, vec % 4);
                    chk("cont_data", out_data, (vec % 4) * 1000 + beat);
                    chk("cont_last", out_last, beat == int'(MC) - 1);
                    if (beat == int'(MC) - 1) begin
                        beat = 0;
                        vec++;
                    end else begin
                        beat++;
                    end
                end else if (started) begin
                    bubbles++;
                end
                tick();
                cyc++;
            end
            chk("cont_vectors", vec, 5);
            chk("cont_bubbles", bubbles, B2B ? 0 : 4);
        end

        // Reset after beat 9 of requester 1, then re-request.
        do_reset();
        fill(1, 32'd700);
        req_valid = 4'b0010;
        #1;
        chk("mid_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            out_ready = 1'b1;
            #1;
            chk("mid_data", out_data, 700 + k);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        fill(1, 32'd800);
        fill(2, 32'd900);
        req_valid = 4'b0110;
        #1;
        chk("mid_rr_restart", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        drain(1, 32'd800, '0);

        // Requester 3 gives up while requester 0 streams.
        do_reset();
        fill(0, 32'd1000);
        fill(3, 32'd3000);
        req_valid = 4'b1001;
        #1;
        chk("drop_ready", req_ready, 4'b0001);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < int'(MC); k++) begin
            req_valid = (k < 5) ? 4'b1000 : 4'b0000;
            #1;
            chk("drop_data", out_data, 1000 + k);
            chk("drop_no_ready", req_ready, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drop_quiet_ready", req_ready, 0);
            chk("drop_quiet_busy", busy, 0);
            tick();
        end

        // Randomized traffic against the behavioural model.
        do_reset();
        begin
            bit            m_busy = 1'b0;
            int            m_id = 0, m_idx = 0, m_ptr = int'(NR) - 1;
            logic [DW-1:0] m_vec [MC];
            for (int c = 0; c < 3000; c++) begin
                bit en;
                int w;
                req_valid = NR'($urandom_range(0, 15));
                for (int r = 0; r < int'(NR); r++) begin
                    if (!req_valid[r]) begin
                        for (int k = 0; k < int'(MC); k++) req_data[r][k] = $urandom;
                    end
                end
                out_ready = ($urandom_range(0, 9) < 7);
                #1;
                en = !m_busy || (B2B && m_idx == int'(MC) - 1 && out_ready);
                w  = en ? pick(req_valid, m_ptr) : -1;
                chk("rnd_ready", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
                chk("rnd_valid", out_valid, m_busy);
                chk("rnd_busy", busy, m_busy);
                if (m_busy) begin
                    chk("rnd_data", out_data, m_vec[m_idx]);
                    chk("rnd_last", out_last, m_idx == int'(MC) - 1);
                    chk("rnd_id", out_id, m_id);
                end
                if (m_busy && out_ready) begin
                    if (m_idx == int'(MC) - 1) m_busy = 1'b0;
                    else m_idx++;
                end
                if (w >= 0) begin
                    m_vec  = req_data[w];
                    m_id   = w;
                    m_ptr  = w;
                    m_idx  = 0;
                    m_busy = 1'b1;
                end
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
